// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg
//   Shared definitions for the pipelined adder/subtractor.
//   - OP_* : operation encodings carried on the 2-bit op field
//   - chunk_width() : bits per carry-chain chunk, ceil(width/stages)
//   - chunk_lsb()   : lowest bit index covered by chunk k
package pipe_adder_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;  // a + b
  localparam logic [1:0] OP_SUB  = 2'b01;  // a + ~b + 1
  localparam logic [1:0] OP_ADDC = 2'b10;  // a + b + ci
  localparam logic [1:0] OP_SUBB = 2'b11;  // a + ~b + ci

  function automatic int chunk_width(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic int chunk_lsb(input int k, input int width, input int stages);
    return k * chunk_width(width, stages);
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if
//   Operand and result channels of pipe_adder.
//   Handshake: a beat transfers on the rising edge where valid && ready are
//   both high. The source holds its payload stable while valid is high and
//   ready is low; ready may depend combinationally on the sink's state.
//   - in_valid/in_ready, a, b, ci, op : operand channel (master -> slave)
//   - out_valid/out_ready, s, co, ovf : result channel  (slave -> master)
interface pipe_adder_if #(
  parameter int WIDTH = 22
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, op, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, op, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/pipe_adder_stage.sv
// pipe_adder_stage
//   One carry-chain chunk of the pipelined adder. Adds chunk K of the
//   operands using the carry from the previous stage, then registers the
//   partial sum, chunk carry, valid bit and the forwarded operands.
//   - clk, rst         : clock, async active-high reset
//   - en               : global pipeline advance (shared by all stages)
//   - vin/vout         : stage valid bit in/out
//   - ain/bin          : operand a and preconditioned b' (skew path)
//   - sin/sout         : partial sum; lower slices already computed (deskew)
//   - cin/cout         : carry into this chunk / carry out of this chunk
//   - ovfin/ovfout     : overflow flag, produced by the MSB chunk stage
module pipe_adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 22,
  parameter int STAGES = 2,
  parameter int K      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             vin,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic [WIDTH-1:0] sin,
  input  logic             cin,
  input  logic             ovfin,
  output logic             vout,
  output logic [WIDTH-1:0] aout,
  output logic [WIDTH-1:0] bout,
  output logic [WIDTH-1:0] sout,
  output logic             cout,
  output logic             ovfout
);

  localparam int CW   = chunk_width(WIDTH, STAGES);
  localparam int LSB  = chunk_lsb(K, WIDTH, STAGES);
  localparam int TOP  = (LSB + CW > WIDTH) ? WIDTH : (LSB + CW);
  localparam int HI   = TOP - 1;
  localparam int CHW  = TOP - LSB;
  localparam bit LAST = (K == STAGES - 1);

  logic [CHW:0]     sum;
  logic [WIDTH-1:0] s_next;
  logic             ovf_next;

  assign sum = {1'b0, ain[HI:LSB]} + {1'b0, bin[HI:LSB]} + {{CHW{1'b0}}, cin};

  always_comb begin
    s_next         = sin;
    s_next[HI:LSB] = sum[CHW-1:0];
  end

  // Carry into the MSB is recovered from the MSB sum bit and its operands;
  // only the stage owning the MSB produces the flag, others pass it along.
  assign ovf_next = LAST ? (ain[HI] ^ bin[HI] ^ sum[CHW-1] ^ sum[CHW]) : ovfin;

  // Full-width a/b are carried so every stage has the same shape; only the
  // bits above this chunk are still needed downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vout   <= 1'b0;
      aout   <= '0;
      bout   <= '0;
      sout   <= '0;
      cout   <= 1'b0;
      ovfout <= 1'b0;
    end else if (en) begin
      vout   <= vin;
      aout   <= ain;
      bout   <= bin;
      sout   <= s_next;
      cout   <= sum[CHW];
      ovfout <= ovf_next;
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder
//   Pipelined WIDTH-bit adder/subtractor split into STAGES carry-chain
//   chunks. Holds operand preconditioning, the global-enable handshake and
//   the output connections; the chunk adders live in pipe_adder_stage.
//   - clk : rising-edge clock
//   - rst : asynchronous active-high reset
//   - bus : pipe_adder_if slave (operand channel in, result channel out)
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 22,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  pipe_adder_if.slave  bus
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH) begin : g_bad_params
    $error("pipe_adder: need WIDTH >= 2 and 1 <= STAGES <= WIDTH");
  end
  // The last chunk would be empty when the first STAGES-1 chunks already
  // cover every bit.
  if ((STAGES - 1) * CW >= WIDTH) begin : g_bad_chunks
    $error("pipe_adder: WIDTH/STAGES leaves a zero-width chunk");
  end

  logic             advance;
  logic [WIDTH-1:0] b_pre;
  logic             c0;

  // Whole pipeline moves together; it only freezes when a result is
  // waiting and downstream refuses it.
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  assign b_pre = bus.op[0] ? ~bus.b : bus.b;

  always_comb begin
    c0 = bus.ci;
    case (bus.op)
      OP_ADD:  c0 = 1'b0;
      OP_SUB:  c0 = 1'b1;
      default: c0 = bus.ci;
    endcase
  end

  logic [STAGES:0]  v_p;
  logic [STAGES:0]  c_p;
  logic [STAGES:0]  o_p;
  logic [WIDTH-1:0] a_p [STAGES+1];
  logic [WIDTH-1:0] b_p [STAGES+1];
  logic [WIDTH-1:0] s_p [STAGES+1];

  assign v_p[0] = bus.in_valid;
  assign c_p[0] = c0;
  assign o_p[0] = 1'b0;
  assign a_p[0] = bus.a;
  assign b_p[0] = b_pre;
  assign s_p[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_adder_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .K      (k)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (advance),
      .vin    (v_p[k]),
      .ain    (a_p[k]),
      .bin    (b_p[k]),
      .sin    (s_p[k]),
      .cin    (c_p[k]),
      .ovfin  (o_p[k]),
      .vout   (v_p[k+1]),
      .aout   (a_p[k+1]),
      .bout   (b_p[k+1]),
      .sout   (s_p[k+1]),
      .cout   (c_p[k+1]),
      .ovfout (o_p[k+1])
    );
  end

  assign bus.out_valid = v_p[STAGES];
  assign bus.s         = s_p[STAGES];
  assign bus.co        = c_p[STAGES];
  assign bus.ovf       = o_p[STAGES];

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder
//   Bench for pipe_adder in two configurations (22/2 and 8/3). Inputs are
//   driven 1 time unit after the rising edge; one monitor samples both DUTs
//   on the falling edge, keeps an arithmetic reference queue per DUT and
//   compares every popped result, plus literal expectations for the
//   directed vectors.
module tb_pipe_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(22)) bus22 ();
  pipe_adder_if #(.WIDTH(8))  bus8  ();

  pipe_adder #(.WIDTH(22), .STAGES(2)) u_dut22 (.clk(clk), .rst(rst), .bus(bus22));
  pipe_adder #(.WIDTH(8),  .STAGES(3)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

  int checks_total  = 0;
  int checks_passed = 0;

  // {ovf, co, s} expectations; lit queues carry a has-literal flag on top.
  logic [23:0] exp22_q[$];
  logic [24:0] lit22_q[$];
  logic [9:0]  exp8_q[$];
  logic [10:0] lit8_q[$];
  logic [24:0] cur_lit22;
  logic [10:0] cur_lit8;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic note_fail(input string name);
    checks_total++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference: whole-word arithmetic, overflow from operand/result signs.
  function automatic logic [63:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic ci, input logic [1:0] op);
    logic [63:0] mask, beff, c0, full, s;
    logic co, ovf;
    mask = (64'd1 << w) - 64'd1;
    beff = op[0] ? (~b & mask) : (b & mask);
    c0   = (op == 2'b01) ? 64'd1 : (op == 2'b00) ? 64'd0 : {63'd0, ci};
    full = (a & mask) + beff + c0;
    s    = full & mask;
    co   = full[w];
    ovf  = (a[w-1] == beff[w-1]) && (s[w-1] != a[w-1]);
    return ({62'd0, ovf, co} << w) | s;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        stall22, stall8;
    logic [23:0] held22;
    logic [9:0]  held8;
    logic [63:0] m;
    logic [24:0] l22;
    logic [10:0] l8;
    stall22 = 1'b0;
    stall8  = 1'b0;
    held22  = '0;
    held8   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp22_q.delete(); lit22_q.delete();
        exp8_q.delete();  lit8_q.delete();
        stall22 = 1'b0;
        stall8  = 1'b0;
      end else begin
        // 22-bit DUT
        if (stall22) check("hold22", {bus22.out_valid, bus22.ovf, bus22.co, bus22.s}, {1'b1, held22});
        if (bus22.out_valid && !bus22.out_ready) check("stall_in_ready22", bus22.in_ready, 0);
        if (bus22.out_valid && bus22.out_ready) begin
          if (exp22_q.size() == 0) note_fail("stale_out22");
          else begin
            check("model22", {bus22.ovf, bus22.co, bus22.s}, exp22_q.pop_front());
            l22 = lit22_q.pop_front();
            if (l22[24]) check("literal22", {bus22.ovf, bus22.co, bus22.s}, l22[23:0]);
          end
        end
        if (bus22.in_valid && bus22.in_ready) begin
          m = model(22, 64'(bus22.a), 64'(bus22.b), bus22.ci, bus22.op);
          exp22_q.push_back(m[23:0]);
          lit22_q.push_back(cur_lit22);
        end
        stall22 = bus22.out_valid && !bus22.out_ready;
        held22  = {bus22.ovf, bus22.co, bus22.s};

        // 8-bit DUT
        if (stall8) check("hold8", {bus8.out_valid, bus8.ovf, bus8.co, bus8.s}, {1'b1, held8});
        if (bus8.out_valid && !bus8.out_ready) check("stall_in_ready8", bus8.in_ready, 0);
        if (bus8.out_valid && bus8.out_ready) begin
          if (exp8_q.size() == 0) note_fail("stale_out8");
          else begin
            check("model8", {bus8.ovf, bus8.co, bus8.s}, exp8_q.pop_front());
            l8 = lit8_q.pop_front();
            if (l8[10]) check("literal8", {bus8.ovf, bus8.co, bus8.s}, l8[9:0]);
          end
        end
        if (bus8.in_valid && bus8.in_ready) begin
          m = model(8, 64'(bus8.a), 64'(bus8.b), bus8.ci, bus8.op);
          exp8_q.push_back(m[9:0]);
          lit8_q.push_back(cur_lit8);
        end
        stall8 = bus8.out_valid && !bus8.out_ready;
        held8  = {bus8.ovf, bus8.co, bus8.s};
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one transaction and returns 1 unit after the edge that took it.
  task automatic send(input bit sel8, input logic [21:0] a, input logic [21:0] b,
                      input logic ci, input logic [1:0] op,
                      input bit has_lit, input logic [23:0] lit);
    int n;
    if (sel8) begin
      bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.ci = ci; bus8.op = op;
      cur_lit8 = {has_lit, lit[9:0]};
      bus8.in_valid = 1'b1;
    end else begin
      bus22.a = a; bus22.b = b; bus22.ci = ci; bus22.op = op;
      cur_lit22 = {has_lit, lit};
      bus22.in_valid = 1'b1;
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (sel8 ? bus8.in_ready : bus22.in_ready) break;
      n++;
      if (n > 100) begin
        note_fail("accept_wait");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus22.in_valid = 1'b0;
    bus8.in_valid  = 1'b0;
  endtask

  task automatic measure_latency(input bit sel8, input int exp_lat, input string name);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(sel8 ? bus8.out_valid : bus22.out_valid) && lat < 20);
    check(name, lat, exp_lat);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp22_q.size() != 0 || exp8_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain22", exp22_q.size(), 0);
    check("drain8",  exp8_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    note_fail("watchdog");
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus22.in_valid = 1'b0; bus22.a = '0; bus22.b = '0; bus22.ci = 1'b0; bus22.op = 2'b00;
    bus22.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.ci = 1'b0; bus8.op = 2'b00;
    bus8.out_ready = 1'b1;
    cur_lit22 = '0;
    cur_lit8  = '0;

    repeat (2) @(negedge clk);
    check("rst_out22", {bus22.out_valid, bus22.ovf, bus22.co, bus22.s}, 0);
    check("rst_out8",  {bus8.out_valid, bus8.ovf, bus8.co, bus8.s}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst22", bus22.in_ready, 1);
    check("in_ready_after_rst8",  bus8.in_ready, 1);
    @(posedge clk); #1;

    // 22-bit directed vectors; literal = {ovf, co, s}
    send(0, 22'h3FFFFF, 22'h000001, 1'b0, 2'b00, 1, {1'b0, 1'b1, 22'h000000});
    idle();
    measure_latency(0, 2, "latency22");
    @(posedge clk); #1;
    send(0, 22'h000005, 22'h000007, 1'b0, 2'b01, 1, {1'b0, 1'b0, 22'h3FFFFE});
    send(0, 22'h000005, 22'h000007, 1'b1, 2'b11, 1, {1'b0, 1'b0, 22'h3FFFFE});
    send(0, 22'h000005, 22'h000007, 1'b0, 2'b11, 1, {1'b0, 1'b0, 22'h3FFFFD});
    send(0, 22'h1FFFFF, 22'h000001, 1'b1, 2'b00, 1, {1'b1, 1'b0, 22'h200000});
    send(0, 22'h000010, 22'h000020, 1'b1, 2'b10, 1, {1'b0, 1'b0, 22'h000031});
    send(0, 22'h200000, 22'h000001, 1'b0, 2'b01, 1, {1'b1, 1'b1, 22'h1FFFFF});
    idle();
    drain();

    // Backpressure: 6 back-to-back random adds, out_ready low 3 cycles
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(0, 22'($urandom_range(0, 32'h3FFFFF)), 22'($urandom_range(0, 32'h3FFFFF)),
               1'b0, 2'b00, 0, 24'd0);
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus22.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus22.out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-flight
    @(posedge clk); #1;
    send(0, 22'h000100, 22'h000200, 1'b0, 2'b00, 0, 24'd0);
    send(0, 22'h000300, 22'h000400, 1'b0, 2'b00, 0, 24'd0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid22", bus22.out_valid, 0);
    check("rst_mid_s22", bus22.s, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_quiet22", bus22.out_valid, 0);
    end
    @(posedge clk); #1;

    // 8-bit, 3 stages (chunks 3/3/2)
    send(1, 22'h0000FF, 22'h000001, 1'b0, 2'b00, 1, {14'd0, 1'b0, 1'b1, 8'h00});
    idle();
    measure_latency(1, 3, "latency8");
    @(posedge clk); #1;
    send(1, 22'h000080, 22'h0000FF, 1'b0, 2'b01, 1, {14'd0, 1'b0, 1'b0, 8'h81});
    send(1, 22'h00005A, 22'h0000A5, 1'b1, 2'b10, 1, {14'd0, 1'b0, 1'b1, 8'h00});
    idle();
    drain();

    // Empty pipeline keeps advancing with out_ready low
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    send(1, 22'h00007F, 22'h000001, 1'b0, 2'b00, 1, {14'd0, 1'b1, 1'b0, 8'h80});
    idle();
    measure_latency(1, 3, "bubble_advance8");
    @(negedge clk);
    @(posedge clk); #1;
    bus8.out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
